btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 114 +++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: debounces a start/stop button and a clear button into run/toggle/clear controls.
// Ports: clk0 clock, rst_n async active-low reset, btn/btn_2 raw buttons (high = pressed),
//   run registered run level, toggle_pulse one cycle per btn press,
//   clear_pulse one-cycle clear request, btn_db debounced levels {btn_2, btn}.
// Define LONG_PRESS_EN to make clear_pulse fire only after btn_2 is held for LONG_CYCLES.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter bit RUN_INIT        = 1'b1
) (
  input  logic       clk0,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       btn_2,
  output logic       run,
  output logic       toggle_pulse,
  output logic       clear_pulse,
  output logic [1:0] btn_db
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_REL} state_t;
  logic [1:0] sync1_q, sync2_q;
  state_t state_q [2];
  state_t state_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0] press;
  logic run_q, run_d, toggle_q, toggle_d, clear_q, clear_d;
  always_comb begin
    press = '0;
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        IDLE: if (sync2_q[c]) begin
          state_d[c] = DB_PRESS;
          cnt_d[c]   = '0;
        end
        DB_PRESS: if (!sync2_q[c]) state_d[c] = IDLE;
          else if (cnt_q[c] == CMAX) begin
            state_d[c] = PRESSED;
            press[c]   = 1'b1;
          end else cnt_d[c] = cnt_q[c] + 1'b1;
        PRESSED: if (!sync2_q[c]) begin
          state_d[c] = DB_REL;
          cnt_d[c]   = '0;
        end
        DB_REL: if (sync2_q[c]) state_d[c] = PRESSED;
          else if (cnt_q[c] == CMAX) state_d[c] = IDLE;
          else cnt_d[c] = cnt_q[c] + 1'b1;
        default: state_d[c] = IDLE;
      endcase
      btn_db[c] = state_q[c] == PRESSED || state_q[c] == DB_REL;
    end
    toggle_d = press[0];
    run_d    = press[0] ? ~run_q : run_q;
  end
`ifdef LONG_PRESS_EN
  localparam int HW = LONG_CYCLES > 1 ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES - 1);
  logic [HW-1:0] hold_q, hold_d;
  logic done_q, done_d;
  // hold restarts only on a fresh press; done_q keeps a saturated hold from re-firing
  always_comb begin
    hold_d  = hold_q;
    done_d  = done_q;
    clear_d = 1'b0;
    if (press[1]) begin
      hold_d = '0;
      done_d = 1'b0;
    end else if (btn_db[1]) begin
      clear_d = hold_q == HMAX && !done_q;
      done_d  = done_q || clear_d;
      hold_d  = hold_q == HMAX ? hold_q : hold_q + 1'b1;
    end
  end
  always_ff @(posedge clk0 or negedge rst_n)
    if (!rst_n) begin
      hold_q <= '0;
      done_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      done_q <= done_d;
    end
`else
  always_comb clear_d = press[1];
`endif
  always_ff @(posedge clk0 or negedge rst_n)
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      run_q    <= RUN_INIT;
      toggle_q <= 1'b0;
      clear_q  <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
      end
    end else begin
      sync1_q  <= {btn_2, btn};
      sync2_q  <= sync1_q;
      run_q    <= run_d;
      toggle_q <= toggle_d;
      clear_q  <= clear_d;
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  assign run          = run_q;
  assign toggle_pulse = toggle_q;
  assign clear_pulse  = clear_q;
endmodule
